// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DefDataW = 256;
  localparam int unsigned DefAddrW = 32;
  localparam int unsigned WdogW    = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant0  = 2'd1,
    StGrant1  = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One memory-side link: request (enable/write/addr/wdata) towards memory, ack/rdata back.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_W = mem_port_arbiter_pkg::DefDataW,
  parameter int unsigned ADDR_W = mem_port_arbiter_pkg::DefAddrW
);
  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  // master issues requests; slave is the side that answers them
  modport master (output enable, write, addr, wdata, input ack, rdata);
  modport slave  (input enable, write, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the requester that was not last served wins.
module mem_port_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the line-wide data memory port between icache (m0) and dcache (m1).
// Grant is held until ack, abort or watchdog timeout; a one-cycle release gap always follows.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  m0,
  mem_port_arbiter_if.slave  m1,
  mem_port_arbiter_if.master mem,
  output logic               err_o,
  output logic [1:0]         grant_o
);

  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic              err_q, err_d;
  logic [1:0]        pick;
  logic              cur_en;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;

  mem_port_rr_pick u_rr_pick (
    .req_i  ({m1.enable, m0.enable}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign cur_en = (state_q == StGrant1) ? m1.enable : m0.enable;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        wdog_d = '0;
        if (pick[0]) begin
          state_d = StGrant0;
        end else if (pick[1]) begin
          state_d = StGrant1;
        end
      end
      StGrant0, StGrant1: begin
        // ack beats both abort and timeout when they coincide
        if (mem.ack || !cur_en || (wdog_q == WdogLast)) begin
          state_d = StRelease;
          last_d  = (state_q == StGrant1);
          wdog_d  = '0;
          if (!mem.ack && cur_en) begin
            err_d = 1'b1;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    mem.enable = 1'b0;
    mem.write  = 1'b0;
    addr_mux   = '0;
    data_mux   = '0;
    m0.ack     = 1'b0;
    m1.ack     = 1'b0;
    grant_o    = 2'b00;
    unique case (state_q)
      StGrant0: begin
        mem.enable = m0.enable;
        mem.write  = m0.write;
        addr_mux   = m0.addr;
        data_mux   = m0.wdata;
        m0.ack     = mem.ack;
        grant_o    = 2'b01;
      end
      StGrant1: begin
        mem.enable = m1.enable;
        mem.write  = m1.write;
        addr_mux   = m1.addr;
        data_mux   = m1.wdata;
        m1.ack     = mem.ack;
        grant_o    = 2'b10;
      end
      default: ;
    endcase
  end

  assign mem.addr  = addr_mux;
  assign mem.wdata = data_mux;
  assign m0.rdata  = mem.rdata;
  assign m1.rdata  = mem.rdata;
  assign err_o     = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// transaction-level run checked against a queue-based model of the arbitration rules.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned DW = 256;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] data;
    int unsigned   lat;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err;
  logic [1:0] grant;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  txn_t       q0[$];
  txn_t       q1[$];

  mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) m0_if ();
  mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) m1_if ();
  mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .mem     (mem_if),
    .err_o   (err),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    m0_if.enable = 1'b0; m0_if.write = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.enable = 1'b0; m1_if.write = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
    mem_if.ack = 1'b0;   mem_if.rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic test_reset();
    idle_inputs();
    m0_if.enable = 1'b1;
    m1_if.enable = 1'b1;
    mem_if.ack   = 1'b1;
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (mem_if.enable !== 1'b0 || mem_if.write !== 1'b0 || mem_if.addr !== '0 || mem_if.wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got en=%b wr=%b addr=%h want all zero", mem_if.enable, mem_if.write, mem_if.addr);
    end
    n_tests++;
    if ({m0_if.ack, m1_if.ack, grant, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got ack=%b%b grant=%b err=%b want 0", m1_if.ack, m0_if.ack, grant, err);
    end
    idle_inputs();
    rst = 1'b0;
    step();
    n_tests++;
    if (grant !== 2'b00 || mem_if.enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got grant=%b en=%b want 00/0", grant, mem_if.enable);
    end
  endtask

  task automatic test_single();
    int acks0 = 0, acks1 = 0, en_cyc = 0;
    m0_if.enable = 1'b1; m0_if.write = 1'b0; m0_if.addr = 32'h0000_0400; m0_if.wdata = rand_line();
    #1;
    n_tests++;
    if (mem_if.enable !== 1'b0) begin
      n_fail++;
      $display("FAIL single_t0: got mem_en=%b want 0", mem_if.enable);
    end
    step();
    n_tests++;
    if (grant !== 2'b01 || mem_if.addr !== 32'h400 || mem_if.write !== 1'b0) begin
      n_fail++;
      $display("FAIL single_t1: got grant=%b addr=%h wr=%b want 01/400/0", grant, mem_if.addr, mem_if.write);
    end
    for (int k = 1; k <= 5; k++) begin
      mem_if.ack = (k == 5);
      #1;
      acks0 += int'(m0_if.ack);
      acks1 += int'(m1_if.ack);
      en_cyc += int'(mem_if.enable);
      step();
    end
    mem_if.ack = 1'b0;
    m0_if.enable = 1'b0;
    #1;
    n_tests++;
    if (acks0 != 1 || acks1 != 0 || en_cyc != 5) begin
      n_fail++;
      $display("FAIL single_ack: got m0_acks=%0d m1_acks=%0d en_cycles=%0d want 1/0/5", acks0, acks1, en_cyc);
    end
    n_tests++;
    if (mem_if.enable !== 1'b0 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL single_release: got en=%b grant=%b want 0/00", mem_if.enable, grant);
    end
    step();
  endtask

  task automatic test_tie();
    int order[$];
    int k = 0, last_ack = 0, bad_gap = 0;
    do_reset();
    m0_if.enable = 1'b1;
    m1_if.enable = 1'b1;
    for (int c = 0; c < 100 && order.size() < 4; c++) begin
      mem_if.ack = 1'b0;
      if (grant != 2'b00) begin
        k++;
        if (k == 1) begin
          if (order.size() > 0 && (cyc - last_ack) != 3) bad_gap++;
          order.push_back(int'(grant[1]));
        end
        if (k == 2) begin
          mem_if.ack = 1'b1;
          last_ack = cyc;
        end
      end else begin
        k = 0;
      end
      step();
    end
    n_tests++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      n_fail++;
      $display("FAIL tie_order: got %p want '{0,1,0,1}", order);
    end
    n_tests++;
    if (bad_gap != 0) begin
      n_fail++;
      $display("FAIL tie_gap: got %0d bad ack-to-grant gaps want 0", bad_gap);
    end
    idle_inputs();
    step();
    step();
    step();
  endtask

  task automatic test_writeback();
    logic [DW-1:0] a5;
    int low = 0;
    for (int i = 0; i < DW / 8; i++) a5[i*8 +: 8] = 8'hA5;
    m1_if.enable = 1'b1; m1_if.write = 1'b1; m1_if.addr = 32'h1FE0; m1_if.wdata = a5;
    step();
    n_tests++;
    if (grant !== 2'b10 || mem_if.write !== 1'b1 || mem_if.wdata !== a5 || mem_if.addr !== 32'h1FE0) begin
      n_fail++;
      $display("FAIL wb_write: got grant=%b wr=%b addr=%h want 10/1/1fe0", grant, mem_if.write, mem_if.addr);
    end
    step();
    mem_if.ack = 1'b1;
    step();
    mem_if.ack = 1'b0;
    m1_if.write = 1'b0;
    for (int c = 0; c < 20 && mem_if.enable !== 1'b1; c++) begin
      low++;
      step();
    end
    n_tests++;
    if (low != 2) begin
      n_fail++;
      $display("FAIL wb_gap: got %0d low cycles want 2", low);
    end
    n_tests++;
    if (grant !== 2'b10 || mem_if.write !== 1'b0 || mem_if.addr !== 32'h1FE0) begin
      n_fail++;
      $display("FAIL wb_refill: got grant=%b wr=%b addr=%h want 10/0/1fe0", grant, mem_if.write, mem_if.addr);
    end
    mem_if.ack = 1'b1;
    #1;
    n_tests++;
    if (m1_if.ack !== 1'b1 || m0_if.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_refill_ack: got m1_ack=%b m0_ack=%b want 1/0", m1_if.ack, m0_if.ack);
    end
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_abort_stray();
    int bad = 0;
    m0_if.enable = 1'b1; m0_if.addr = 32'h0000_2000;
    step();
    step();
    step();
    m0_if.enable = 1'b0;
    #1;
    n_tests++;
    if (mem_if.enable !== 1'b0 || m0_if.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_drop: got en=%b ack=%b want 0/0", mem_if.enable, m0_if.ack);
    end
    step();
    n_tests++;
    if (grant !== 2'b00 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release: got grant=%b err=%b want 00/0", grant, err);
    end
    step();
    for (int c = 0; c < 4; c++) begin
      mem_if.ack = 1'b1;
      #1;
      if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0 || grant !== 2'b00) bad++;
      step();
    end
    mem_if.ack = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stray_ack: got %0d cycles with forwarded ack want 0", bad);
    end
  endtask

  task automatic test_timeout();
    int hi = 0, acks = 0, waited = 0;
    m0_if.enable = 1'b1; m0_if.addr = 32'h0000_3040;
    for (int c = 0; c < 40; c++) begin
      step();
      if (mem_if.enable === 1'b1) begin
        hi++;
        acks += int'(m0_if.ack);
      end else if (hi > 0) begin
        break;
      end
    end
    m0_if.enable = 1'b0;
    n_tests++;
    if (hi != int'(TO) || acks != 0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: got en_cycles=%0d acks=%0d err=%b want %0d/0/1", hi, acks, err, TO);
    end
    m1_if.enable = 1'b1; m1_if.addr = 32'h0000_5000;
    while (grant !== 2'b10 && waited < 10) begin
      step();
      waited++;
    end
    mem_if.ack = 1'b1;
    #1;
    n_tests++;
    if (grant !== 2'b10 || m1_if.ack !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_next: got grant=%b m1_ack=%b err=%b want 10/1/1", grant, m1_if.ack, err);
    end
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid_grant();
    m1_if.enable = 1'b1; m1_if.addr = 32'h0000_6000;
    step();
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (mem_if.enable !== 1'b0 || grant !== 2'b00 || err !== 1'b0 || m1_if.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got en=%b grant=%b err=%b want 0/00/0", mem_if.enable, grant, err);
    end
    rst = 1'b0;
    m0_if.enable = 1'b1;
    step();
    n_tests++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_tie: got grant=%b want 01", grant);
    end
    mem_if.ack = 1'b1;
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic drive_heads();
    m0_if.enable = (q0.size() > 0);
    m1_if.enable = (q1.size() > 0);
    if (q0.size() > 0) begin
      m0_if.write = q0[0].write; m0_if.addr = q0[0].addr; m0_if.wdata = q0[0].data;
    end
    if (q1.size() > 0) begin
      m1_if.write = q1[0].write; m1_if.addr = q1[0].addr; m1_if.wdata = q1[0].data;
    end
  endtask

  task automatic test_random();
    logic exp_last = 1'b1, exp_err = 1'b0, acked;
    int   who, s, n0, n1;
    txn_t t;
    do_reset();
    n0 = $urandom_range(2, 6);
    n1 = $urandom_range(2, 6);
    for (int i = 0; i < n0 + n1; i++) begin
      t.addr  = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
      t.write = 1'($urandom_range(0, 1));
      t.data  = rand_line();
      t.lat   = ($urandom_range(0, 5) == 0) ? TO + $urandom_range(1, 3) : $urandom_range(1, TO);
      if (i == n0) t.lat = TO;
      if (i < n0) q0.push_back(t);
      else q1.push_back(t);
    end
    drive_heads();
    s = cyc + 1;
    while (q0.size() > 0 || q1.size() > 0) begin
      if (q0.size() > 0 && q1.size() > 0) who = exp_last ? 0 : 1;
      else who = (q1.size() > 0) ? 1 : 0;
      t = (who == 1) ? q1[0] : q0[0];
      while (cyc < s) begin
        mem_if.ack = ($urandom_range(0, 3) == 0);
        #1;
        n_tests++;
        if (grant !== 2'b00 || mem_if.enable !== 1'b0 || m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0 ||
            err !== exp_err) begin
          n_fail++;
          $display("FAIL rnd_gap@%0d: got grant=%b en=%b ack=%b%b err=%b want 00/0/00/%b", cyc, grant,
                   mem_if.enable, m1_if.ack, m0_if.ack, err, exp_err);
        end
        step();
      end
      acked = 1'b0;
      for (int k = 1; k <= int'(TO); k++) begin
        mem_if.ack   = (k == int'(t.lat));
        mem_if.rdata = rand_line();
        #1;
        n_tests++;
        if (grant !== ((who == 1) ? 2'b10 : 2'b01) || mem_if.enable !== 1'b1 ||
            mem_if.addr !== t.addr || mem_if.write !== t.write || mem_if.wdata !== t.data ||
            ((who == 1) ? m1_if.ack : m0_if.ack) !== mem_if.ack ||
            ((who == 1) ? m0_if.ack : m1_if.ack) !== 1'b0 || err !== exp_err) begin
          n_fail++;
          $display("FAIL rnd_grant@%0d: got grant=%b en=%b addr=%h wr=%b ack=%b%b err=%b want m%0d addr=%h wr=%b",
                   cyc, grant, mem_if.enable, mem_if.addr, mem_if.write, m1_if.ack, m0_if.ack, err,
                   who, t.addr, t.write);
        end
        step();
        if (k == int'(t.lat)) begin
          acked = 1'b1;
          break;
        end
      end
      if (who == 1) void'(q1.pop_front());
      else void'(q0.pop_front());
      drive_heads();
      mem_if.ack = 1'b0;
      if (!acked) exp_err = 1'b1;
      exp_last = (who == 1);
      s = cyc + 2;
    end
    step();
    n_tests++;
    if (grant !== 2'b00 || err !== exp_err) begin
      n_fail++;
      $display("FAIL rnd_end: got grant=%b err=%b want 00/%b", grant, err, exp_err);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_writeback();
    test_abort_stray();
    test_timeout();
    test_reset_mid_grant();
    for (int r = 0; r < 4; r++) test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 256-bit line-wide data memory port between two cache controllers: requester 0 is the instruction cache, requester 1 is the data cache.
- Sits between both cache controllers' memory-side interfaces (enable/write/addr/data/ack) and the data memory.
- Fair round-robin arbitration.
- Grant is held until the memory acknowledges.
- A watchdog flags transactions the memory never acknowledges.

Parameters:
- DATA_W, 256, memory line width in bits
- ADDR_W, 32, byte address width
- TIMEOUT_CYCLES, 64, cycles in a grant without ack before abort; range 2..255

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- m0_enable_i  in  1  requester 0 transaction request; held until ack
- m0_write_i  in  1  requester 0: 1 = line write, 0 = line read
- m0_addr_i  in  ADDR_W  requester 0 line address (low 5 bits zero)
- m0_data_i  in  DATA_W  requester 0 write data
- m0_ack_o  out  1  requester 0 acknowledge
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o  same as m0_* for requester 1
- mem_data_i  in  DATA_W  memory read data; broadcast to both requesters by the parent
- mem_ack_i  in  1  memory acknowledge
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write select
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- err_o  out  1  sticky timeout flag
- grant_o  out  2  one-hot current grant, for debug/perf

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: state=IDLE; last=1 (so m0 wins the first tie); all mem_* outputs 0; both ack outputs 0; err_o=0; grant_o=0; watchdog=0.
- Reset asserted mid-grant: the transaction is dropped with no ack and the state returns to IDLE. The memory sees mem_enable_o fall the next cycle.
- States: IDLE, GRANT0, GRANT1, RELEASE.
- IDLE:
  - Only m0_enable_i high -> GRANT0.
  - Only m1_enable_i high -> GRANT1.
  - Both high -> grant the requester != last.
  - Neither high -> stay in IDLE.
- GRANTn, mem_* outputs (combinational from requester n):
  - mem_enable_o = mn_enable_i
  - mem_write_o = mn_write_i
  - mem_addr_o = mn_addr_i
  - mem_data_o = mn_data_i
  - grant_o bit n = 1
- GRANTn, ack routing:
  - mn_ack_o = mem_ack_i, combinational, same cycle.
  - The other requester's ack is always 0.
- GRANTn, exits:
  - mem_ack_i=1 -> RELEASE; last<=n; watchdog cleared.
  - mn_enable_i drops before ack (abort) -> RELEASE; last<=n; no ack issued.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no ack -> err_o<=1 (sticky until reset); RELEASE; last<=n.
  - When mem_ack_i and the timeout coincide, the ack wins and err_o is not set.
- Watchdog: 8-bit counter. Increments each GRANT cycle, cleared on entry to GRANT.
- Outside GRANT (IDLE, RELEASE): all mem_* outputs 0, both acks 0, grant_o=0.
- RELEASE: lasts exactly one cycle, then IDLE.
  - Guarantees mem_enable_o is low for at least 2 cycles between transactions.
  - Absorbs a requester that holds enable one cycle past its ack.
- Latency:
  - Request seen in IDLE at cycle t -> mem_enable_o high at t+1.
  - Ack at cycle a -> earliest next grant at a+3.
- Stray mem_ack_i in IDLE or RELEASE: ignored, not forwarded.
- Back-to-back: a requester that keeps enable high after an ack (write-back followed by refill) re-competes in IDLE. If the other requester is also waiting, the other one wins.
- No internal data storage: data passes straight through, so there is no full/empty condition.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2, RELEASE=2'd3.
  - Default line width and address width.
- One natural sub-module: mem_port_rr_pick. It is the combinational 2-way round-robin picker (req[1:0], last -> one-hot gnt).
- Watchdog and output muxes stay in the top module.

Test Plan:
- Single request: m0 read addr 0x0000_0400, memory acks after 10 cycles -> mem_enable_o high from t+1; mem_addr_o=0x400, mem_write_o=0; m0_ack_o pulses once with the ack; m1_ack_o stays 0.
- Simultaneous requests: after reset, m0 and m1 both request at cycle t -> m0 granted first. After m0's ack, m1 is granted 3 cycles later. Repeating with both held high alternates m0, m1, m0, m1.
- Dcache write-back then refill: m1 write addr 0x1FE0, data 0xA5..A5, held high through the ack, then read of same line -> two distinct mem_enable_o windows separated by ≥2 low cycles; write data on mem_data_o; second window has mem_write_o=0.
- Timeout: memory never acks with TIMEOUT_CYCLES=8 -> mem_enable_o high for exactly 8 cycles, err_o=1 thereafter, no ack to the requester; a following m1 request is still served.
- Abort and stray ack: m0 drops enable after 3 cycles -> RELEASE, no ack. mem_ack_i=1 pulsed in IDLE -> no mN_ack_o.
- Reset mid-grant: rst_i pulses during GRANT1 -> next cycle all outputs 0 and err_o=0; a later tie grants m0.
